// File: rtl/stdp_sweep_sched.sv
// stdp_sweep_sched
// Timestep scheduler in front of the sequential STDP weight-update core.
// Incoming per-timestep pre/post spike vectors are buffered in a small FIFO.
// For each queued timestep the scheduler runs one sweep. A sweep drives
// stdp_enable for exactly F*N consecutive cycles, so the core's (f,n) walk
// starts and ends at pair (0,0). The scheduler then spends one drain cycle
// on the core's registered final write and pulses sweep_done.
//
// Ports
//   clk, rst_n        clock (rising edge) / async active-low reset
//   step_valid/ready  timestep handshake; ready = !full && !abort
//   step_pre/post     spike vectors of the offered timestep
//   learn_en          permits starting a new sweep
//   abort             flushes queued (not yet started) timesteps
//   stdp_enable       registered enable to the core
//   stdp_pre/post_bits registered vectors, held for the whole sweep
//   pair_cnt          pair index of the current cycle (valid with enable)
//   sweep_busy        high in SWEEP and DRAIN
//   sweep_done        one-cycle pulse in DRAIN (final write committed)
//   steps_done        completed sweeps, wraps modulo 2^32
//   q_count           queue occupancy
`timescale 1ns/1ps
module stdp_sweep_sched #(
    parameter int F     = 48,
    parameter int N     = 96,
    parameter int DEPTH = 2,
    localparam int PAIRS = F * N,
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1,
    localparam int QW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step_valid,
    output logic          step_ready,
    input  logic [F-1:0]  step_pre,
    input  logic [N-1:0]  step_post,
    input  logic          learn_en,
    input  logic          abort,
    output logic          stdp_enable,
    output logic [F-1:0]  stdp_pre_bits,
    output logic [N-1:0]  stdp_post_bits,
    output logic [CW-1:0] pair_cnt,
    output logic          sweep_busy,
    output logic          sweep_done,
    output logic [31:0]   steps_done,
    output logic [QW-1:0] q_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef struct packed {
        logic [F-1:0] pre;
        logic [N-1:0] post;
    } step_t;

    step_t         mem [DEPTH];
    step_t         head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    state;
    logic          full, push, pop, last_pair;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (q_count == QW'(DEPTH));
    assign step_ready = !full && !abort;
    assign push       = step_valid && step_ready;
    // A new sweep may start from IDLE or straight out of DRAIN, which gives
    // exactly one enable-low cycle between back-to-back sweeps. Only stored
    // entries are popped, so there is no bypass from step_* to the core.
    assign pop        = ((state == IDLE) || (state == DRAIN)) && (q_count != '0)
                        && learn_en && !abort;
    assign last_pair  = (pair_cnt == CW'(PAIRS - 1));
    assign sweep_busy = (state != IDLE);
    assign head       = mem[rd_ptr];

    // Queue storage: data needs no reset, occupancy/pointers do.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pre: step_pre, post: step_post};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (abort) begin
            // push is already blocked by step_ready and pop by the pop term
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Sweep FSM. Once started, a sweep ignores learn_en/abort until its
    // last pair so the core's index walk always lands back on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            stdp_enable    <= 1'b0;
            stdp_pre_bits  <= '0;
            stdp_post_bits <= '0;
            pair_cnt       <= '0;
            sweep_done     <= 1'b0;
            steps_done     <= '0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE, DRAIN: begin
                    if (pop) begin
                        stdp_pre_bits  <= head.pre;
                        stdp_post_bits <= head.post;
                        stdp_enable    <= 1'b1;
                        pair_cnt       <= '0;
                        state          <= SWEEP;
                    end else begin
                        state <= IDLE;
                    end
                end
                SWEEP: begin
                    if (last_pair) begin
                        stdp_enable <= 1'b0;
                        pair_cnt    <= '0;
                        sweep_done  <= 1'b1;
                        steps_done  <= steps_done + 32'd1;
                        state       <= DRAIN;
                    end else begin
                        pair_cnt <= pair_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
